// File: rtl/leaf_ce_pkg.sv
// Shared state encoding and counter types for the leaf clock-enable scheduler.
package leaf_ce_pkg;

    typedef enum logic [2:0] {
        StOff,
        StPend,
        StSettle,
        StOn,
        StHold
    } leaf_state_e;

    // Wide enough for the largest hold count (255); settle counts fit as well.
    localparam int unsigned CntW = 8;
    typedef logic [CntW-1:0] leaf_cnt_t;

    // A leaf consumes budget whenever its clock enable is driven by the FSM.
    function automatic logic is_active(input leaf_state_e s);
        return s inside {StSettle, StOn, StHold};
    endfunction

endpackage

// File: rtl/leaf_ce_fsm.sv
// Per-leaf request/settle/hold FSM; exposes next-state activity so the top can
// register CE and the active count in the same edge as the state change.
module leaf_ce_fsm
    import leaf_ce_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic grant,
    output logic pend,
    output logic active_nxt,
    output logic ack
);

    localparam leaf_cnt_t SettleLoad = leaf_cnt_t'(SETTLE_CYC);
    localparam leaf_cnt_t HoldLoad   = leaf_cnt_t'(HOLD_CYC);
    localparam leaf_cnt_t CntOne     = leaf_cnt_t'(1);

    leaf_state_e state_q, state_d;
    leaf_cnt_t   cnt_q, cnt_d;
    logic        ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StOff: begin
                if (req) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (!req) begin
                    state_d = StOff;
                end else if (grant) begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end
            end
            StSettle, StOn: begin
                if (!req) begin
                    // A zero hold time releases the leaf straight away.
                    if (HOLD_CYC == 0) begin
                        state_d = StOff;
                        cnt_d   = '0;
                    end else begin
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                    end
                end else if (state_q == StSettle) begin
                    if (cnt_q <= CntOne) begin
                        state_d = StOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StHold: begin
                if (req) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end else if (cnt_q <= CntOne) begin
                    state_d = StOff;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend       = (state_q == StPend);
        active_nxt = is_active(state_d);
        ack_d      = (state_d == StOn);
        ack        = ack_q;
    end

endmodule

// File: rtl/leaf_ce_sched.sv
// Leaf clock-enable scheduler: round-robin grants of pending leaves under an
// active-leaf budget, with a force-all override on the registered CE outputs.
module leaf_ce_sched
    import leaf_ce_pkg::*;
#(
    parameter int unsigned NUM_LEAF   = 4,
    parameter int unsigned MAX_ON     = 2,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 8,
    localparam int unsigned CntOutW   = $clog2(NUM_LEAF + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEAF-1:0] req,
    input  logic                force_on,
    output logic [NUM_LEAF-1:0] ce,
    output logic [NUM_LEAF-1:0] ack,
    output logic [CntOutW-1:0]  on_cnt
);

    localparam int unsigned PtrW = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;

    logic [NUM_LEAF-1:0] pend;
    logic [NUM_LEAF-1:0] active_nxt;
    logic [NUM_LEAF-1:0] grant;
    logic [NUM_LEAF-1:0] cand;
    logic [NUM_LEAF-1:0] ce_q, ce_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [PtrW-1:0]     gidx;
    logic [CntOutW-1:0]  on_cnt_q, on_cnt_d;
    logic                found;
    logic                budget_ok;
    int unsigned         idx;

    for (genvar i = 0; i < NUM_LEAF; i++) begin : g_leaf
        leaf_ce_fsm #(
            .SETTLE_CYC(SETTLE_CYC),
            .HOLD_CYC  (HOLD_CYC)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[i]),
            .grant     (grant[i]),
            .pend      (pend[i]),
            .active_nxt(active_nxt[i]),
            .ack       (ack[i])
        );
    end

    // Budget uses the registered count, i.e. the occupancy before this edge,
    // so a simultaneous release never makes room for a grant in the same edge.
    always_comb begin
        cand      = pend & req;
        grant     = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        gidx      = '0;
        idx       = 0;
        budget_ok = (32'(on_cnt_q) < MAX_ON);
        for (int unsigned k = 0; k < NUM_LEAF; k++) begin
            idx = (32'(ptr_q) + k) % NUM_LEAF;
            if (!found && cand[idx]) begin
                found = 1'b1;
                gidx  = PtrW'(idx);
            end
        end
        if (found && budget_ok) begin
            grant[gidx] = 1'b1;
            ptr_d       = (32'(gidx) == NUM_LEAF - 1) ? '0 : gidx + PtrW'(1);
        end
    end

    always_comb begin
        on_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_LEAF; i++) begin
            on_cnt_d = on_cnt_d + CntOutW'(active_nxt[i]);
        end
        ce_d = force_on ? '1 : active_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            on_cnt_q <= '0;
            ce_q     <= '0;
        end else begin
            ptr_q    <= ptr_d;
            on_cnt_q <= on_cnt_d;
            ce_q     <= ce_d;
        end
    end

    assign ce     = ce_q;
    assign on_cnt = on_cnt_q;

endmodule

// File: tb/tb_leaf_ce_sched.sv
// Scoreboard bench for leaf_ce_sched: stimulus queues expected outputs keyed by
// cycle, a monitor samples at each falling clock edge and at reset assertion.
module tb_leaf_ce_sched;

    typedef struct packed {
        int         key;
        logic [3:0] ce;
        logic [3:0] ack;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ce;
    logic [3:0] ack;
    logic [2:0] on_cnt;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    mon_key;
    int    t0, t1, t2;

    leaf_ce_sched #(
        .NUM_LEAF  (4),
        .MAX_ON    (2),
        .SETTLE_CYC(2),
        .HOLD_CYC  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .force_on(force_on),
        .ce      (ce),
        .ack     (ack),
        .on_cnt  (on_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Samples taken while clk is high come from a reset assertion mid-cycle.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        mon_key = clk ? cyc * 2 : cyc * 2 + 1;
        while (exp_q.size() > 0 && exp_q[0].key <= mon_key) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (mon_e.key < mon_key) begin
                errors++;
                $display("FAIL %s: sample slot %0d passed unchecked (now %0d)",
                         mon_n, mon_e.key, mon_key);
            end else if (ce !== mon_e.ce || ack !== mon_e.ack || on_cnt !== mon_e.cnt) begin
                errors++;
                $display("FAIL %s: got ce=%b ack=%b on_cnt=%0d, want ce=%b ack=%b on_cnt=%0d",
                         mon_n, ce, ack, on_cnt, mon_e.ce, mon_e.ack, mon_e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exp_at(input int at, input bit on_rst, input logic [3:0] e_ce,
                          input logic [3:0] e_ack, input logic [2:0] e_cnt, input string nm);
        exp_t e;
        int   k;
        int   pos;
        k   = on_rst ? at * 2 : at * 2 + 1;
        e   = '{key: k, ce: e_ce, ack: e_ack, cnt: e_cnt};
        pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].key > k) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
        name_q.insert(pos, nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        req      = '0;
        force_on = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d expectations left, want 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        force_on = 1'b0;
        exp_at(2, 0, 4'b0000, 4'b0000, 3'd0, "reset_state");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single request, then short and long drops of the request.
        step(1);
        t0  = cyc;
        req = 4'b0001;
        exp_at(t0 + 1, 0, 4'b0000, 4'b0000, 3'd0, "A_pend");
        exp_at(t0 + 2, 0, 4'b0001, 4'b0000, 3'd1, "A_ce_edge2");
        exp_at(t0 + 3, 0, 4'b0001, 4'b0000, 3'd1, "A_settling");
        exp_at(t0 + 4, 0, 4'b0001, 4'b0001, 3'd1, "A_ack_edge4");
        step(5);
        t1  = cyc;
        req = 4'b0000;
        exp_at(t1 + 1, 0, 4'b0001, 4'b0000, 3'd1, "A_hold_enter");
        exp_at(t1 + 5, 0, 4'b0001, 4'b0000, 3'd1, "A_hold_5");
        step(5);
        req = 4'b0001;
        exp_at(t1 + 6, 0, 4'b0001, 4'b0001, 3'd1, "A_rehit_ack");
        step(2);
        t2  = cyc;
        req = 4'b0000;
        exp_at(t2 + 1, 0, 4'b0001, 4'b0000, 3'd1, "A_drop9_hold");
        exp_at(t2 + 8, 0, 4'b0001, 4'b0000, 3'd1, "A_drop9_edge8");
        exp_at(t2 + 9, 0, 4'b0000, 4'b0000, 3'd0, "A_drop9_off");
        step(10);
        drain("A");

        // Budget of two with all four leaves requesting.
        do_reset();
        step(1);
        t0  = cyc;
        req = 4'b1111;
        exp_at(t0 + 1, 0, 4'b0000, 4'b0000, 3'd0, "B_all_pend");
        exp_at(t0 + 2, 0, 4'b0001, 4'b0000, 3'd1, "B_grant0");
        exp_at(t0 + 3, 0, 4'b0011, 4'b0000, 3'd2, "B_grant1");
        exp_at(t0 + 4, 0, 4'b0011, 4'b0001, 3'd2, "B_ack0");
        exp_at(t0 + 5, 0, 4'b0011, 4'b0011, 3'd2, "B_ack1_full");
        step(6);
        t1  = cyc;
        req = 4'b1110;
        exp_at(t1 + 1, 0, 4'b0011, 4'b0010, 3'd2, "B_leaf0_hold");
        exp_at(t1 + 8, 0, 4'b0011, 4'b0010, 3'd2, "B_still_full");
        exp_at(t1 + 9, 0, 4'b0010, 4'b0010, 3'd1, "B_leaf0_off_nogrant");
        exp_at(t1 + 10, 0, 4'b0110, 4'b0010, 3'd2, "B_grant2");
        exp_at(t1 + 12, 0, 4'b0110, 4'b0110, 3'd2, "B_ack2");
        step(14);
        drain("B");

        // Request dropped during settle: CE held for the hold time, no ACK.
        do_reset();
        step(1);
        t0  = cyc;
        req = 4'b0010;
        exp_at(t0 + 1, 0, 4'b0000, 4'b0000, 3'd0, "C_pend");
        for (int i = 2; i <= 11; i++) begin
            exp_at(t0 + i, 0, (i <= 10) ? 4'b0010 : 4'b0000, 4'b0000,
                   (i <= 10) ? 3'd1 : 3'd0, $sformatf("C_abort_e%0d", i));
        end
        step(2);
        req = 4'b0000;
        step(12);
        drain("C");

        // Force override with no requests.
        do_reset();
        step(1);
        t0       = cyc;
        force_on = 1'b1;
        exp_at(t0 + 1, 0, 4'b1111, 4'b0000, 3'd0, "D_force_on");
        exp_at(t0 + 2, 0, 4'b1111, 4'b0000, 3'd0, "D_force_held");
        exp_at(t0 + 3, 0, 4'b0000, 4'b0000, 3'd0, "D_force_release");
        step(2);
        force_on = 1'b0;
        step(3);
        drain("D");

        // Asynchronous reset with two leaves on, then re-grant.
        do_reset();
        step(1);
        t0  = cyc;
        req = 4'b0011;
        exp_at(t0 + 2, 0, 4'b0001, 4'b0000, 3'd1, "E_grant0");
        exp_at(t0 + 3, 0, 4'b0011, 4'b0000, 3'd2, "E_grant1");
        exp_at(t0 + 5, 0, 4'b0011, 4'b0011, 3'd2, "E_both_on");
        exp_at(t0 + 6, 1, 4'b0000, 4'b0000, 3'd0, "E_async_rst");
        exp_at(t0 + 6, 0, 4'b0000, 4'b0000, 3'd0, "E_in_rst");
        step(6);
        #1;
        rst_n = 1'b0;
        step(2);
        #1;
        rst_n = 1'b1;
        t1    = cyc;
        exp_at(t1 + 1, 0, 4'b0000, 4'b0000, 3'd0, "E_repend");
        exp_at(t1 + 2, 0, 4'b0001, 4'b0000, 3'd1, "E_regrant_ce");
        exp_at(t1 + 3, 0, 4'b0011, 4'b0000, 3'd2, "E_regrant1");
        exp_at(t1 + 4, 0, 4'b0011, 4'b0001, 3'd2, "E_reack");
        step(6);
        drain("E");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaf_ce_sched.md
LEAF_CE_SCHED -- requirements
Module: leaf_ce_sched

Interface
REQ-001 Parameter NUM_LEAF, default 4: number of leaf clock buffers controlled (2..16).
REQ-002 Parameter MAX_ON, default 2: maximum leaves with CE active at once from requests (1..NUM_LEAF).
REQ-003 Parameter SETTLE_CYC, default 2: cycles CE is held high before ACK is asserted (1..15).
REQ-004 Parameter HOLD_CYC, default 8: cycles CE is held after REQ drops (0..255).
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 REQ  in  NUM_LEAF  per-leaf clock request, level, synchronous to CLK.
REQ-008 FORCE_ON  in  1  force all CE high; bypasses the budget.
REQ-009 CE  out  NUM_LEAF  registered clock-enable to each leaf buffer.
REQ-010 ACK  out  NUM_LEAF  registered grant: the leaf clock is running and stable.
REQ-011 ON_CNT  out  clog2(NUM_LEAF+1)  registered count of leaves in SETTLE, ON or HOLD.

Function
REQ-012 Each leaf SHALL have an independent FSM: OFF, PEND, SETTLE, ON, HOLD.
REQ-013 OFF->PEND when REQ[i]=1; PEND->OFF when REQ[i]=0.
REQ-014 Active count SHALL be the number of leaves in SETTLE, ON or HOLD; a grant is allowed only if active count < MAX_ON.
REQ-015 At most one PEND leaf SHALL be granted per cycle, chosen round-robin starting at the index after the last granted leaf (pointer resets to 0).
REQ-016 Granted leaf SHALL enter SETTLE with counter = SETTLE_CYC; CE[i]=1 from the same edge.
REQ-017 SETTLE->ON when the counter reaches 0; ACK[i]=1 from that edge, i.e. REQ rising in cycle 0 with budget free gives CE at edge 2 and ACK at edge 2+SETTLE_CYC.
REQ-018 ON->HOLD when REQ[i]=0; ACK[i]=0 from that edge; CE[i] stays 1; hold counter = HOLD_CYC.
REQ-019 HOLD->ON when REQ[i]=1 before expiry; ACK[i]=1 from that edge, with no re-settle.
REQ-020 HOLD->OFF when the hold counter reaches 0 with REQ[i]=0; CE[i]=0 from that edge. HOLD_CYC=0 SHALL give ON->OFF directly.
REQ-021 REQ[i]=0 during SETTLE SHALL go to HOLD; ACK never asserts for that request.
REQ-022 A grant and a HOLD->OFF in the same cycle SHALL use the active count from before the edge; no over-budget grant.
REQ-023 FORCE_ON=1 SHALL drive all CE to 1 at the next edge without changing FSM state, ACK or ON_CNT; on release, CE returns to FSM-derived values at the next edge.
REQ-024 ACK[i]=1 SHALL imply CE[i]=1 in every cycle.

Reset
REQ-025 RST_N=0 SHALL asynchronously set all FSMs to OFF, counters and the RR pointer to 0, and CE, ACK and ON_CNT to 0.
REQ-026 Assertion mid-operation SHALL drop CE and ACK immediately. After release, requests still high are re-arbitrated from PEND.

Structure
REQ-027 FSM state encoding and counter widths SHALL live in shared package leaf_ce_pkg.
REQ-028 The per-leaf FSM plus counters SHALL be sub-module leaf_ce_fsm, instantiated NUM_LEAF times. The arbiter and budget logic SHALL stay in the top.

Verification
REQ-029 Single request: defaults, REQ[0] rises at cycle 0 -> CE[0]=1 at edge 2, ACK[0]=1 at edge 4, ON_CNT=1.
REQ-030 Budget: REQ=4'b1111 together -> leaves 0 and 1 granted in successive cycles. Leaves 2 and 3 stay PEND, ON_CNT=2, until leaf 0 completes HOLD; then leaf 2 is granted.
REQ-031 Hysteresis: drop REQ[0] for 5 cycles, then reassert -> CE[0] stays 1 and ACK[0] returns 1 edge later. Drop for 9 cycles -> CE[0]=0 at the 9th edge after the drop.
REQ-032 Abort in SETTLE: REQ[1] pulses for 2 cycles -> CE[1] high for 1+HOLD_CYC cycles, ACK[1] never 1.
REQ-033 FORCE_ON with all REQ=0 -> CE=4'b1111 at the next edge, ACK=0, ON_CNT=0. Release -> CE=0 at the next edge.
REQ-034 Async reset while two leaves are ON -> CE, ACK and ON_CNT are 0 without a clock edge. Re-grant after release follows REQ-029 timing.
